clock_divider_multi: RTL
========================

Name: clock_divider_multi

Overview:
- Programmable multi-channel clock/strobe divider; each channel has a runtime divisor and high-time (duty cycle).
- Each channel has its own enable, and all channels share one clock domain.
- Divisor and duty changes are loaded through a valid/ready configuration port. They take effect glitch-free at the channel's period boundary.
- Provides a global phase-sync input. Feeds LED blinkers, display scan and UART/baud timing logic.

Parameters:
- N_CH, 4, number of independent divider channels (1..16)
- CNT_W, 28, counter/divisor width in bits
- DEFAULT_DIV, 2, divisor loaded into every channel at reset (≥2)

Ports:
- clock_in  in  1  system clock; all logic on its rising edge
- rst_n  in  1  asynchronous active-low reset
- en  in  N_CH  per-channel run enable
- sync  in  1  single-cycle pulse; restarts the phase of all running channels
- cfg_valid  in  1  configuration request
- cfg_ready  out  1  configuration can be accepted for cfg_ch
- cfg_ch  in  $clog2(N_CH) (min 1)  target channel
- cfg_div  in  CNT_W  requested divisor
- cfg_high  in  CNT_W  requested high-time, in input cycles
- cfg_err  out  1  one-cycle pulse: request rejected
- clock_out  out  N_CH  divided clocks, registered
- tick  out  N_CH  one-cycle pulse on the last input cycle of each period, registered

Behaviour:
- Reset (async assert, sync-released deassert use is the integrator's job):
  - clock_out=0, tick=0, cfg_err=0
  - every channel in CH_IDLE with cnt=0
  - active div=DEFAULT_DIV, active high=DEFAULT_DIV/2, pending=0
- Per-channel state CH_IDLE / CH_RUN:
  - IDLE→RUN when en[ch]=1. The first RUN cycle has cnt=0; a pending shadow config is applied on this transition.
  - RUN→IDLE when en[ch]=0. On the next edge cnt=0, clock_out[ch]=0, tick[ch]=0. Pending config is retained.
- RUN, each edge:
  - cnt <= (cnt==div-1) ? 0 : cnt+1
  - clock_out[ch] <= (cnt < high)
  - tick[ch] <= (cnt==div-1)
  - Output latency: one cycle behind cnt.
- Period = div cycles; high phase = high cycles, then low for div-high cycles.
- div=1: clock_out[ch] held 1 and tick[ch]=1 every RUN cycle.
- Config handshake:
  - cfg_ready = !pending[cfg_ch].
  - Accept on cfg_valid&&cfg_ready. Shadow <= {cfg_div, clamped high}; pending[cfg_ch] <= 1.
  - cfg_div=0 → not accepted; cfg_err pulses the following cycle. cfg_err also pulses if cfg_ch ≥ N_CH.
  - High clamp: cfg_high=0 → 1; cfg_high ≥ cfg_div → cfg_div-1 (div≥2); div=1 ignores high.
- Shadow apply:
  - In RUN, the shadow is applied at the wrap edge (cnt==div-1) together with cnt<=0.
  - pending clears on that edge, so the new period starts cleanly and no runt pulse is produced.
- Simultaneous events:
  - Accept on a channel's wrap edge: the wrap uses the old active config; the new config applies at the following wrap.
  - sync=1: every RUN channel gets cnt<=0 and applies its pending shadow on that edge. sync overrides a wrap.
  - cfg accepted in the same cycle as sync stays pending.
  - sync on an IDLE channel has no effect.
- Arithmetic: all comparisons are unsigned CNT_W. cnt never exceeds div-1, including after a div decrease, because changes apply only at wrap or sync.

Decomposition:
- Package clock_divider_pkg:
  - typedef enum ch_state_t {CH_IDLE, CH_RUN}
  - CNT_W default constant
  - function clamp_high(div, high)
- Sub-module clock_divider_ch: one channel (state, cnt, active/shadow registers, outputs), instantiated N_CH times by a generate loop.
- Top level holds the cfg decode, cfg_ready mux and cfg_err.

Test Plan:
- Reset then en=4'b0001, defaults (DEFAULT_DIV=2): clock_out[0] toggles 1,0,1,0 starting one cycle after the first RUN cycle; tick[0] high on every second cycle; other channels stay 0.
- cfg ch1 div=5 high=2, en[1]=1: clock_out[1] repeats 1,1,0,0,0; tick[1] coincides with the last 0.
- Mid-period reconfig of ch0 (running div=4 high=2) to div=6 high=3, accepted at cnt=1: the old 1,1,0,0 period completes, then 1,1,1,0,0,0. A second cfg to ch0 sees cfg_ready=0 until the wrap.
- cfg_div=0 and cfg_ch=N_CH → cfg_err pulses once each and no state changes. cfg_high=9 with div=4 → high clamped to 3 (pattern 1,1,1,0).
- Channels 0/1 at div=3/div=7 with arbitrary phase; pulse sync → both restart with cnt=0 on the same edge, and their first clock_out rises align.
- Assert rst_n low mid-period with en held high → all outputs 0 immediately (async). After release, channels restart at DEFAULT_DIV with pending cleared.

Source files
------------

// File: rtl/clock_divider_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : clock_divider_pkg                                            |
// | Description : Shared types, constants and high-time clamp for the divider. |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package clock_divider_pkg;

    localparam int c_cnt_w  = 28;
    localparam int c_wide_w = 64;

    typedef logic [c_wide_w-1:0] wide_t;

    typedef enum logic [0:0] {
        CH_IDLE = 1'b0,
        CH_RUN  = 1'b1
    } ch_state_t;

    // Keeps the high phase at least one cycle and leaves at least one low cycle.
    function automatic wide_t clamp_high(input wide_t div, input wide_t high);
        wide_t w_res;
        if (div == wide_t'(1))
            w_res = wide_t'(1);
        else if (high == '0)
            w_res = wide_t'(1);
        else if (high >= div)
            w_res = div - wide_t'(1);
        else
            w_res = high;
        return w_res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/clock_divider_multi_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : clock_divider_multi_if                                       |
// | Description : Configuration valid/ready port of the multi-channel divider. |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
interface clock_divider_multi_if
    import clock_divider_pkg::*;
#(
    parameter int N_CH  = 4,
    parameter int CNT_W = c_cnt_w
);
    localparam int c_ch_w = (N_CH > 1) ? $clog2(N_CH) : 1;

    logic              cfg_valid;
    logic              cfg_ready;
    logic [c_ch_w-1:0] cfg_ch;
    logic [CNT_W-1:0]  cfg_div;
    logic [CNT_W-1:0]  cfg_high;
    logic              cfg_err;

    modport master (
        output cfg_valid, cfg_ch, cfg_div, cfg_high,
        input  cfg_ready, cfg_err
    );

    modport slave (
        input  cfg_valid, cfg_ch, cfg_div, cfg_high,
        output cfg_ready, cfg_err
    );

endinterface
`default_nettype wire

// File: rtl/clock_divider_ch.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : clock_divider_ch                                             |
// | Description : One divider channel with active and shadow configuration.    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module clock_divider_ch
    import clock_divider_pkg::*;
#(
    parameter int CNT_W       = c_cnt_w,
    parameter int DEFAULT_DIV = 2
) (
    input  wire             clock_in,
    input  wire             rst_n,
    input  wire             i_en,
    input  wire             i_sync,
    input  wire             i_load,
    input  wire [CNT_W-1:0] i_load_div,
    input  wire [CNT_W-1:0] i_load_high,
    output logic            o_pending,
    output logic            o_clock,
    output logic            o_tick
);

    localparam logic [CNT_W-1:0] c_def_div  = CNT_W'(DEFAULT_DIV);
    localparam logic [CNT_W-1:0] c_def_high = CNT_W'(DEFAULT_DIV / 2);

    ch_state_t        r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic [CNT_W-1:0] r_div, w_div_nxt;
    logic [CNT_W-1:0] r_high, w_high_nxt;
    logic [CNT_W-1:0] r_sh_div, r_sh_high;
    logic             r_pending, w_pending_nxt;
    logic             r_clock, w_clock_nxt;
    logic             r_tick, w_tick_nxt;
    logic             w_wrap;
    logic             w_apply;

    assign w_wrap = (r_cnt == r_div - CNT_W'(1));

    always_ff @(posedge clock_in or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= CH_IDLE;
            r_cnt     <= '0;
            r_div     <= c_def_div;
            r_high    <= c_def_high;
            r_sh_div  <= c_def_div;
            r_sh_high <= c_def_high;
            r_pending <= 1'b0;
            r_clock   <= 1'b0;
            r_tick    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_div     <= w_div_nxt;
            r_high    <= w_high_nxt;
            r_pending <= w_pending_nxt;
            r_clock   <= w_clock_nxt;
            r_tick    <= w_tick_nxt;
            if (i_load) begin
                r_sh_div  <= i_load_div;
                r_sh_high <= i_load_high;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_div_nxt   = r_div;
        w_high_nxt  = r_high;
        w_clock_nxt = 1'b0;
        w_tick_nxt  = 1'b0;
        w_apply     = 1'b0;
        case (r_state)
            CH_IDLE: begin
                if (i_en) begin
                    w_state_nxt = CH_RUN;
                    w_cnt_nxt   = '0;
                    w_apply     = r_pending;
                end
            end
            CH_RUN: begin
                if (!i_en) begin
                    w_state_nxt = CH_IDLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_clock_nxt = (r_cnt < r_high);
                    w_tick_nxt  = w_wrap;
                    // Shadow swaps only at a period restart, so no runt pulse.
                    if (i_sync || w_wrap) begin
                        w_cnt_nxt = '0;
                        w_apply   = r_pending;
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                end
            end
            default: w_state_nxt = CH_IDLE;
        endcase
        if (w_apply) begin
            w_div_nxt  = r_sh_div;
            w_high_nxt = r_sh_high;
        end
        // Load requires !pending and apply requires pending, so they never coincide.
        w_pending_nxt = i_load ? 1'b1 : (w_apply ? 1'b0 : r_pending);
    end

    assign o_pending = r_pending;
    assign o_clock   = r_clock;
    assign o_tick    = r_tick;

endmodule
`default_nettype wire

// File: rtl/clock_divider_multi.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : clock_divider_multi                                          |
// | Description : N-channel programmable clock/strobe divider with cfg port.   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module clock_divider_multi
    import clock_divider_pkg::*;
#(
    parameter int N_CH        = 4,
    parameter int CNT_W       = c_cnt_w,
    parameter int DEFAULT_DIV = 2
) (
    input  wire              clock_in,
    input  wire              rst_n,
    input  wire  [N_CH-1:0]  en,
    input  wire              sync,
    clock_divider_multi_if.slave cfg,
    output logic [N_CH-1:0]  clock_out,
    output logic [N_CH-1:0]  tick
);

    logic [N_CH-1:0]  w_pending;
    logic [N_CH-1:0]  w_load;
    logic [CNT_W-1:0] w_load_high;
    logic             w_sel_pending;
    logic             w_ch_ok;
    logic             w_div_ok;
    logic             w_accept;
    logic             w_err;
    logic             r_err;

    assign w_ch_ok  = (int'(cfg.cfg_ch) < N_CH);
    assign w_div_ok = (cfg.cfg_div != '0);

    // Out-of-range channels read as ready so the request completes and errors.
    always_comb begin
        w_sel_pending = 1'b0;
        for (int i = 0; i < N_CH; i++) begin
            if (int'(cfg.cfg_ch) == i)
                w_sel_pending = w_pending[i];
        end
    end

    assign cfg.cfg_ready = !w_sel_pending;
    assign w_accept      = cfg.cfg_valid && cfg.cfg_ready && w_ch_ok && w_div_ok;
    assign w_err         = cfg.cfg_valid && cfg.cfg_ready && !(w_ch_ok && w_div_ok);
    assign w_load_high   = CNT_W'(clamp_high(wide_t'(cfg.cfg_div), wide_t'(cfg.cfg_high)));

    always_comb begin
        w_load = '0;
        for (int i = 0; i < N_CH; i++) begin
            w_load[i] = w_accept && (int'(cfg.cfg_ch) == i);
        end
    end

    always_ff @(posedge clock_in or negedge rst_n) begin
        if (!rst_n)
            r_err <= 1'b0;
        else
            r_err <= w_err;
    end

    assign cfg.cfg_err = r_err;

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        clock_divider_ch #(
            .CNT_W       (CNT_W),
            .DEFAULT_DIV (DEFAULT_DIV)
        ) u_ch (
            .clock_in    (clock_in),
            .rst_n       (rst_n),
            .i_en        (en[g]),
            .i_sync      (sync),
            .i_load      (w_load[g]),
            .i_load_div  (cfg.cfg_div),
            .i_load_high (w_load_high),
            .o_pending   (w_pending[g]),
            .o_clock     (clock_out[g]),
            .o_tick      (tick[g])
        );
    end

endmodule
`default_nettype wire
